tube_scheduler: RTL and testbench

- Owns the position, gap height and motion of every pipe pair in the flappy-bird playfield.
- Scrolls the pipes left on each frame tick, respawns them at the right edge with an LFSR-chosen gap, and scores a point when a pipe passes the bird.
- For each scanned pixel it reports which tube tile covers that pixel and the tile-local coordinates. These feed the 16x16 tube sprite ROM and the pixel mixer.

---
 rtl/tube_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_tube_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tube_scheduler.sv
// rtl/tube_scheduler.sv - pipe-pair position, gap, scroll, scoring and per-pixel tile lookup
//
// Ports:
//   clk          in   pixel/system clock
//   rst          in   synchronous active-high reset
//   frame_tick   in   one-cycle pulse per frame; scrolls the pipes while running
//   start        in   begins a game from idle, or restarts one after a crash
//   crash        in   collision pulse; freezes scrolling
//   px, py       in   current scan coordinate (11 bits each)
//   tile_sel     out  0 none, 1 body, 2 upper cap, 3 lower cap (registered, 1 cycle after px/py)
//   loc_x, loc_y out  tile-local coordinate inside the 16x16 sprite
//   tube_hit     out  pixel lies inside solid pipe
//   score        out  pipes passed, saturating at 255
//   score_pulse  out  one-cycle pulse per score increment
//   running      out  high while the game scrolls

module tube_scheduler #(
  parameter int NUM_TUBES = 3,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int TUBE_W    = 16,
  parameter int CAP_H     = 16,
  parameter int SPACING   = 240,
  parameter int SPEED     = 2,
  parameter int GAP_H     = 96,
  parameter int GAP_MIN   = 64,
  parameter int BIRD_X    = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        crash,
  input  logic [10:0] px,
  input  logic [10:0] py,
  output logic [1:0]  tile_sel,
  output logic [10:0] loc_x,
  output logic [10:0] loc_y,
  output logic        tube_hit,
  output logic [7:0]  score,
  output logic        score_pulse,
  output logic        running
);

  // All coordinate math is 12-bit so gap_top + GAP_H + CAP_H never wraps.
  localparam logic [11:0] SPEED_C    = 12'(SPEED);
  localparam logic [11:0] TUBE_W_C   = 12'(TUBE_W);
  localparam logic [11:0] CAP_H_C    = 12'(CAP_H);
  localparam logic [11:0] GAP_H_C    = 12'(GAP_H);
  localparam logic [11:0] GAP_MIN_C  = 12'(GAP_MIN);
  localparam logic [11:0] GAP_INIT_C = 12'(GAP_MIN + 64);
  localparam logic [11:0] BIRD_X_C   = 12'(BIRD_X);
  localparam logic [11:0] SCREEN_H_C = 12'(SCREEN_H);
  localparam logic [11:0] RESPAWN_C  = 12'(NUM_TUBES * SPACING);
  localparam logic [11:0] BODY_LOC_Y = 12'd8;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  localparam logic [1:0] TILE_NONE = 2'd0;
  localparam logic [1:0] TILE_BODY = 2'd1;
  localparam logic [1:0] TILE_UCAP = 2'd2;
  localparam logic [1:0] TILE_LCAP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2
  } state_t;

  // Right edge (exclusive) of each slot; columns x_off-TUBE_W .. x_off-1.
  function automatic logic [11:0] init_x(input int idx);
    return 12'(SCREEN_W + TUBE_W + idx * SPACING);
  endfunction

  state_t      state_q;
  logic [11:0] x_off_q   [NUM_TUBES];
  logic [11:0] gap_top_q [NUM_TUBES];
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [7:0]  score_q;
  logic        score_pulse_q;
  logic        running_q;

  logic [11:0] scroll_x_d   [NUM_TUBES];
  logic [11:0] scroll_gap_d [NUM_TUBES];
  logic        pass_any_d;

  logic [1:0]  tile_sel_q, tile_sel_d;
  logic [10:0] loc_x_q, loc_x_d;
  logic [10:0] loc_y_q, loc_y_d;
  logic        tube_hit_q;

  // Fibonacci LFSR, taps 16,14,13,11.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Candidate positions for a scroll edge; committed only in RUN on frame_tick.
  always_comb begin
    pass_any_d = 1'b0;
    for (int i = 0; i < NUM_TUBES; i++) begin
      if (x_off_q[i] > SPEED_C) begin
        scroll_x_d[i]   = x_off_q[i] - SPEED_C;
        scroll_gap_d[i] = gap_top_q[i];
      end else begin
        scroll_x_d[i]   = RESPAWN_C;
        scroll_gap_d[i] = GAP_MIN_C + {5'd0, lfsr_q[6:0]};
      end
      // Crossing the bird column from right to left; a respawn jumps right and never counts.
      if ((x_off_q[i] > BIRD_X_C) && (scroll_x_d[i] <= BIRD_X_C)) begin
        pass_any_d = 1'b1;
      end
    end
  end

  // Game state machine with registered running/score outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      score_q       <= 8'd0;
      score_pulse_q <= 1'b0;
      running_q     <= 1'b0;
      for (int i = 0; i < NUM_TUBES; i++) begin
        x_off_q[i]   <= init_x(i);
        gap_top_q[i] <= GAP_INIT_C;
      end
    end else begin
      lfsr_q        <= lfsr_d;
      score_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FROZEN: begin
          if (start) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
            score_q   <= 8'd0;
            for (int i = 0; i < NUM_TUBES; i++) begin
              x_off_q[i]   <= init_x(i);
              gap_top_q[i] <= GAP_INIT_C;
            end
          end
        end
        S_RUN: begin
          // crash outranks any scroll on this edge; start is ignored here.
          if (crash) begin
            state_q   <= S_FROZEN;
            running_q <= 1'b0;
          end else if (frame_tick) begin
            for (int i = 0; i < NUM_TUBES; i++) begin
              x_off_q[i]   <= scroll_x_d[i];
              gap_top_q[i] <= scroll_gap_d[i];
            end
            if (pass_any_d && (score_q != 8'hFF)) begin
              score_q       <= score_q + 8'd1;
              score_pulse_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-pixel tile lookup; lowest slot index that covers solid pipe wins.
  logic [11:0] px_w, py_w;
  logic [11:0] g_c;
  logic [11:0] cand_ly;
  logic [1:0]  cand_sel;
  logic        col_hit;
  logic        hit_found;

  assign px_w = {1'b0, px};
  assign py_w = {1'b0, py};

  always_comb begin
    tile_sel_d = TILE_NONE;
    loc_x_d    = 11'd0;
    loc_y_d    = 11'd0;
    hit_found  = 1'b0;
    g_c        = 12'd0;
    cand_sel   = TILE_NONE;
    cand_ly    = 12'd0;
    col_hit    = 1'b0;
    for (int i = 0; i < NUM_TUBES; i++) begin
      g_c      = gap_top_q[i];
      cand_sel = TILE_NONE;
      cand_ly  = 12'd0;
      // px + TUBE_W >= x_off avoids underflow when x_off < TUBE_W near the left edge.
      col_hit  = (px_w + TUBE_W_C >= x_off_q[i]) && (px_w < x_off_q[i]);
      if (py_w < g_c - CAP_H_C) begin
        cand_sel = TILE_BODY;
        cand_ly  = BODY_LOC_Y;
      end else if (py_w < g_c) begin
        cand_sel = TILE_UCAP;
        cand_ly  = py_w - (g_c - CAP_H_C);
      end else if (py_w < g_c + GAP_H_C) begin
        cand_sel = TILE_NONE;
      end else if (py_w < g_c + GAP_H_C + CAP_H_C) begin
        cand_sel = TILE_LCAP;
        cand_ly  = py_w - (g_c + GAP_H_C);
      end else if (py_w < SCREEN_H_C) begin
        cand_sel = TILE_BODY;
        cand_ly  = BODY_LOC_Y;
      end
      if (!hit_found && col_hit && (cand_sel != TILE_NONE)) begin
        hit_found  = 1'b1;
        tile_sel_d = cand_sel;
        loc_x_d    = 11'(px_w + TUBE_W_C - x_off_q[i]);
        loc_y_d    = 11'(cand_ly);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_sel_q <= TILE_NONE;
      loc_x_q    <= 11'd0;
      loc_y_q    <= 11'd0;
      tube_hit_q <= 1'b0;
    end else begin
      tile_sel_q <= tile_sel_d;
      loc_x_q    <= loc_x_d;
      loc_y_q    <= loc_y_d;
      tube_hit_q <= (tile_sel_d != TILE_NONE);
    end
  end

  assign tile_sel    = tile_sel_q;
  assign loc_x       = loc_x_q;
  assign loc_y       = loc_y_q;
  assign tube_hit    = tube_hit_q;
  assign score       = score_q;
  assign score_pulse = score_pulse_q;
  assign running     = running_q;

endmodule

// File: tb/tb_tube_scheduler.sv
// tb/tb_tube_scheduler.sv - directed self-checking bench for tube_scheduler

module tb_tube_scheduler;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        start;
  logic        crash;
  logic [10:0] px;
  logic [10:0] py;
  logic [1:0]  tile_sel;
  logic [10:0] loc_x;
  logic [10:0] loc_y;
  logic        tube_hit;
  logic [7:0]  score;
  logic        score_pulse;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] lfsr_m;
  logic [15:0] lfsr_prev;
  logic [11:0] exp_gap;
  int          pulses;
  int          cycles;

  tube_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start       (start),
    .crash       (crash),
    .px          (px),
    .py          (py),
    .tile_sel    (tile_sel),
    .loc_x       (loc_x),
    .loc_y       (loc_y),
    .tube_hit    (tube_hit),
    .score       (score),
    .score_pulse (score_pulse),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR runs beside the DUT; lfsr_prev is the value the DUT used on the last edge.
  always @(posedge clk) begin
    lfsr_prev <= lfsr_m;
    lfsr_m    <= rst ? 16'hACE1 : lfsr_step(lfsr_m);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  task automatic pix(input string tag, input int x, input int y,
                     input int e_sel, input int e_lx, input int e_ly);
    px = 11'(x);
    py = 11'(y);
    step();
    check_eq({tag, "_sel"}, tile_sel, e_sel);
    check_eq({tag, "_hit"}, tube_hit, (e_sel != 0));
    if (e_sel != 0) begin
      check_eq({tag, "_lx"}, loc_x, e_lx);
      check_eq({tag, "_ly"}, loc_y, e_ly);
    end
  endtask

  task automatic check_home(input string tag);
    check_eq({tag, "_x0"}, dut.x_off_q[0], 656);
    check_eq({tag, "_x1"}, dut.x_off_q[1], 896);
    check_eq({tag, "_x2"}, dut.x_off_q[2], 1136);
    check_eq({tag, "_g0"}, dut.gap_top_q[0], 128);
    check_eq({tag, "_score"}, score, 0);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; crash = 1'b0;
    px = 11'd0; py = 11'd0;
    step();
    rst = 1'b0;

    // Reset state
    check_home("rst");
    check_eq("rst_run", running, 0);
    check_eq("rst_pulse", score_pulse, 0);
    check_eq("rst_tile", tile_sel, 0);
    check_eq("rst_lfsr", dut.lfsr_q, 16'hACE1);

    // Idle ignores frame ticks
    ticks(20);
    check_home("idle");
    check_eq("idle_run", running, 0);
    check_eq("idle_lfsr", dut.lfsr_q, lfsr_m);

    // Start, then one scroll
    start = 1'b1; step(); start = 1'b0;
    check_eq("start_run", running, 1);
    check_home("start");
    ticks(1);
    check_eq("scroll1_x0", dut.x_off_q[0], 654);
    check_eq("scroll1_x1", dut.x_off_q[1], 894);
    pix("p640", 640, 0, 1, 2, 8);

    // Score: 162 -> 160 crosses the bird column
    ticks(246);
    check_eq("pre_pass_x0", dut.x_off_q[0], 162);
    check_eq("pre_pass_score", score, 0);
    ticks(1);
    check_eq("pass_x0", dut.x_off_q[0], 160);
    check_eq("pass_score", score, 1);
    check_eq("pass_pulse", score_pulse, 1);
    step();
    check_eq("pass_pulse_end", score_pulse, 0);
    check_eq("pass_score_hold", score, 1);

    // Cap mapping with x_off[0]=100, gap_top 128
    ticks(30);
    check_eq("cap_x0", dut.x_off_q[0], 100);
    check_eq("cap_x1", dut.x_off_q[1], 340);
    pix("ucap", 90, 120, 2, 6, 8);
    pix("lcap", 90, 230, 3, 6, 6);
    pix("gap", 90, 150, 0, 0, 0);
    pix("left", 84, 0, 1, 0, 8);
    pix("right", 99, 111, 1, 15, 8);
    pix("ucap0", 99, 112, 2, 15, 0);
    pix("ucap15", 90, 127, 2, 6, 15);
    pix("gap_top", 90, 128, 0, 0, 0);
    pix("gap_bot", 90, 223, 0, 0, 0);
    pix("lcap0", 90, 224, 3, 6, 0);
    pix("lbody", 90, 240, 1, 6, 8);
    pix("lbody_end", 90, 479, 1, 6, 8);
    pix("offscreen", 90, 480, 0, 0, 0);
    pix("past_edge", 100, 0, 0, 0, 0);
    pix("before", 83, 0, 0, 0, 0);

    // Respawn from x_off=2
    ticks(49);
    check_eq("pre_resp_x0", dut.x_off_q[0], 2);
    ticks(1);
    exp_gap = 12'd64 + {5'd0, lfsr_prev[6:0]};
    check_eq("resp_x0", dut.x_off_q[0], 720);
    check_eq("resp_gap", dut.gap_top_q[0], exp_gap);
    check_eq("resp_gap_range", (dut.gap_top_q[0] >= 64) && (dut.gap_top_q[0] <= 191), 1);
    check_eq("resp_x1", dut.x_off_q[1], 240);
    check_eq("resp_x2", dut.x_off_q[2], 480);
    check_eq("resp_score", score, 1);

    // start is ignored while running
    start = 1'b1; frame_tick = 1'b1; step(); start = 1'b0; frame_tick = 1'b0;
    check_eq("run_start_x0", dut.x_off_q[0], 718);
    check_eq("run_start_score", score, 1);
    check_eq("run_start_run", running, 1);

    // crash and start together: crash wins, no scroll
    crash = 1'b1; start = 1'b1; frame_tick = 1'b1; step();
    crash = 1'b0; start = 1'b0; frame_tick = 1'b0;
    check_eq("crash_run", running, 0);
    check_eq("crash_x0", dut.x_off_q[0], 718);
    ticks(5);
    check_eq("frozen_x0", dut.x_off_q[0], 718);
    check_eq("frozen_x1", dut.x_off_q[1], 238);
    check_eq("frozen_score", score, 1);
    pix("frozen_pix", 230, 300, 1, 8, 8);

    // Restart from FROZEN with a tick on the same edge: reload only
    start = 1'b1; frame_tick = 1'b1; step(); start = 1'b0; frame_tick = 1'b0;
    check_eq("restart_run", running, 1);
    check_home("restart");

    // Run to saturation and count pulses
    pulses = 0;
    cycles = 0;
    frame_tick = 1'b1;
    while ((score != 8'd255) && (cycles < 40000)) begin
      step();
      cycles++;
      if (score_pulse) pulses++;
    end
    check_eq("sat_reached", score, 255);
    check_eq("sat_pulses", pulses, 255);
    pulses = 0;
    repeat (400) begin
      step();
      if (score_pulse) pulses++;
    end
    check_eq("sat_hold", score, 255);
    check_eq("sat_no_pulse", pulses, 0);

    // Reset mid-scroll
    rst = 1'b1; step(); rst = 1'b0;
    frame_tick = 1'b0;
    check_home("midrst");
    check_eq("midrst_run", running, 0);
    check_eq("midrst_pulse", score_pulse, 0);
    check_eq("midrst_tile", tile_sel, 0);
    check_eq("midrst_lfsr", dut.lfsr_q, 16'hACE1);
    ticks(3);
    check_eq("midrst_idle_x0", dut.x_off_q[0], 656);
    check_eq("midrst_idle_lfsr", dut.lfsr_q, lfsr_m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
